muldiv_unit: RTL and testbench

- Iterative unsigned multiply/divide execution unit. It sits directly downstream of the register file.
- Operands come from regfile rd1/rd2. The result, destination address and write strobe drive the regfile write port (wd3, wa3, we3) through writeback.
- It handles the MUL, UDIV and UMOD instructions that the single-cycle ALU does not implement.
- Fixed latency of WIDTH cycles. The control unit stalls the pipeline while busy is high.

---
 rtl/muldiv_unit.sv | 152 +++++++++++++++
 tb/tb_muldiv_unit.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit
// Brief    : Iterative unsigned MUL / UDIV / UMOD unit, fixed WIDTH-cycle latency.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
    parameter int WIDTH        = 24,
    parameter int ADDRESSWIDTH = 4,
    parameter int CNTWIDTH     = 5
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic                    flush,
    input  logic [1:0]              op,
    input  logic [WIDTH-1:0]        a,
    input  logic [WIDTH-1:0]        b,
    input  logic [ADDRESSWIDTH-1:0] wa_in,
    output logic                    busy,
    output logic                    result_valid,
    output logic [WIDTH-1:0]        result,
    output logic [ADDRESSWIDTH-1:0] wa_out
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BUSY  = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [1:0] OP_MUL  = 2'b00;
    localparam logic [1:0] OP_UDIV = 2'b01;
    localparam logic [1:0] OP_UMOD = 2'b10;

    localparam logic [CNTWIDTH-1:0] C_LAST = CNTWIDTH'(WIDTH - 1);

    logic [1:0]              state_q, state_d;
    logic [CNTWIDTH-1:0]     cnt_q;
    logic [1:0]              op_q;
    logic [WIDTH-1:0]        opa_q, opa_d;
    logic [WIDTH-1:0]        opb_q, opb_d;
    logic [WIDTH-1:0]        acc_q, acc_d;
    logic [WIDTH-1:0]        rem_q, rem_d;
    logic [ADDRESSWIDTH-1:0] wa_q;
    logic [WIDTH-1:0]        result_q, result_d;
    logic [ADDRESSWIDTH-1:0] wa_out_q;

    logic                    w_accept;
    logic                    w_last;
    logic [WIDTH:0]          w_rem_shift;
    logic [WIDTH:0]          w_diff;

    assign w_accept = (state_q != S_BUSY) && start && !flush;
    assign w_last   = (cnt_q == C_LAST);

    // Restoring-division trial subtract on the (WIDTH+1)-bit partial remainder.
    assign w_rem_shift = {rem_q, opa_q[WIDTH-1]};
    assign w_diff      = w_rem_shift - {1'b0, opb_q};

    always_comb begin
        opa_d    = opa_q;
        opb_d    = opb_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        result_d = '0;
        if (op_q == OP_MUL) begin
            acc_d = opb_q[0] ? (acc_q + opa_q) : acc_q;
            opa_d = opa_q << 1;
            opb_d = opb_q >> 1;
        end else begin
            // The quotient shifts in at the bottom of opa as the dividend leaves its top.
            if (!w_diff[WIDTH]) begin
                rem_d = w_diff[WIDTH-1:0];
                opa_d = {opa_q[WIDTH-2:0], 1'b1};
            end else begin
                rem_d = w_rem_shift[WIDTH-1:0];
                opa_d = {opa_q[WIDTH-2:0], 1'b0};
            end
        end
        case (op_q)
            OP_MUL:  result_d = acc_d;
            OP_UDIV: result_d = opa_d;
            OP_UMOD: result_d = rem_d;
            default: result_d = '0;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  state_d = start ? S_BUSY : S_IDLE;
                S_BUSY:  state_d = w_last ? S_DONE : S_BUSY;
                S_DONE:  state_d = start ? S_BUSY : S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Output logic
    always_comb begin
        busy         = (state_q == S_BUSY);
        result_valid = (state_q == S_DONE);
        result       = result_q;
        wa_out       = wa_out_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q    <= '0;
            op_q     <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            wa_q     <= '0;
            result_q <= '0;
            wa_out_q <= '0;
        end else if (w_accept) begin
            cnt_q <= '0;
            op_q  <= op;
            opa_q <= a;
            opb_q <= b;
            acc_q <= '0;
            rem_q <= '0;
            wa_q  <= wa_in;
        end else if ((state_q == S_BUSY) && !flush) begin
            cnt_q <= cnt_q + CNTWIDTH'(1);
            opa_q <= opa_d;
            opb_q <= opb_d;
            acc_q <= acc_d;
            rem_q <= rem_d;
            if (w_last) begin
                result_q <= result_d;
                wa_out_q <= wa_q;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_unit
// Brief    : Directed self-checking bench for muldiv_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

    localparam int WIDTH = 24;
    localparam int AW    = 4;
    localparam int BOUND = 40;

    logic             clk;
    logic             reset_n;
    logic             start;
    logic             flush;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [AW-1:0]    wa_in;
    logic             busy;
    logic             result_valid;
    logic [WIDTH-1:0] result;
    logic [AW-1:0]    wa_out;

    int n_tests = 0;
    int n_fail  = 0;

    muldiv_unit #(.WIDTH(WIDTH), .ADDRESSWIDTH(AW), .CNTWIDTH(5)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .flush        (flush),
        .op           (op),
        .a            (a),
        .b            (b),
        .wa_in        (wa_in),
        .busy         (busy),
        .result_valid (result_valid),
        .result       (result),
        .wa_out       (wa_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one start cycle; returns 1ns after the accepting edge.
    task automatic issue(input logic [1:0] o, input logic [WIDTH-1:0] x,
                         input logic [WIDTH-1:0] y, input logic [AW-1:0] w);
        op = o; a = x; b = y; wa_in = w; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Counts edges until result_valid is seen, bounded.
    task automatic run_to_valid(output int cyc);
        cyc = 0;
        while (!result_valid && cyc < BOUND) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        n_tests++;
        if ({busy, result_valid, result, wa_out} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got busy=%0b valid=%0b result=%h wa=%0d, want all zero",
                     busy, result_valid, result, wa_out);
        end
    endtask

    task automatic test_mul;
        int cyc;
        issue(2'b00, 24'h000123, 24'h000456, 4'd3);
        a = 24'h777777; b = 24'h555555;
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mul_busy: got %0b want 1", busy);
        end
        run_to_valid(cyc);
        n_tests++;
        if (cyc != WIDTH) begin
            n_fail++;
            $display("FAIL mul_latency: got %0d want %0d", cyc, WIDTH);
        end
        n_tests++;
        if (result !== 24'h04EDC2 || wa_out !== 4'd3 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mul_result: got result=%h wa=%0d busy=%0b want 04edc2/3/0",
                     result, wa_out, busy);
        end
        idle_cycles(1);
        n_tests++;
        if (result_valid !== 1'b0 || result !== 24'h04EDC2 || wa_out !== 4'd3) begin
            n_fail++;
            $display("FAIL mul_hold: got valid=%0b result=%h wa=%0d want 0/04edc2/3",
                     result_valid, result, wa_out);
        end
    endtask

    task automatic test_arith;
        int cyc;
        logic [1:0]       ops [3] = '{2'b00, 2'b01, 2'b10};
        logic [WIDTH-1:0] xs  [3] = '{24'hFFFFFF, 24'h0003E8, 24'h0003E8};
        logic [WIDTH-1:0] ys  [3] = '{24'h000002, 24'h000007, 24'h000007};
        logic [WIDTH-1:0] exp [3] = '{24'hFFFFFE, 24'h00008E, 24'h000006};
        for (int i = 0; i < 3; i++) begin
            issue(ops[i], xs[i], ys[i], AW'(i + 5));
            run_to_valid(cyc);
            n_tests++;
            if (cyc != WIDTH || result !== exp[i] || wa_out !== AW'(i + 5)) begin
                n_fail++;
                $display("FAIL arith_%0d: got cyc=%0d result=%h wa=%0d want %0d/%h/%0d",
                         i, cyc, result, wa_out, WIDTH, exp[i], i + 5);
            end
            idle_cycles(1);
        end
    endtask

    task automatic test_div_zero;
        int cyc;
        logic [1:0]       ops [3] = '{2'b01, 2'b10, 2'b11};
        logic [WIDTH-1:0] exp [3] = '{24'hFFFFFF, 24'h00ABCD, 24'h000000};
        for (int i = 0; i < 3; i++) begin
            issue(ops[i], 24'h00ABCD, (i == 2) ? 24'h000009 : 24'h000000, 4'd9);
            run_to_valid(cyc);
            n_tests++;
            if (cyc != WIDTH || result !== exp[i]) begin
                n_fail++;
                $display("FAIL divzero_%0d: got cyc=%0d result=%h want %0d/%h",
                         i, cyc, result, WIDTH, exp[i]);
            end
            idle_cycles(1);
        end
    endtask

    task automatic test_back_to_back;
        int cyc;
        issue(2'b01, 24'h0003E8, 24'h000007, 4'd1);
        run_to_valid(cyc);
        // Issue the next op while result_valid is high.
        issue(2'b00, 24'h000010, 24'h000011, 4'd2);
        n_tests++;
        if (busy !== 1'b1 || result_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_accept: got busy=%0b valid=%0b want 1/0", busy, result_valid);
        end
        run_to_valid(cyc);
        n_tests++;
        if (cyc != WIDTH || result !== 24'h000110 || wa_out !== 4'd2) begin
            n_fail++;
            $display("FAIL b2b_result: got cyc=%0d result=%h wa=%0d want %0d/000110/2",
                     cyc, result, wa_out, WIDTH);
        end
        idle_cycles(1);
    endtask

    task automatic test_ignored_start;
        int cyc;
        issue(2'b01, 24'h0003E8, 24'h000007, 4'd4);
        idle_cycles(5);
        issue(2'b00, 24'h000100, 24'h000100, 4'd7);
        run_to_valid(cyc);
        n_tests++;
        if (cyc != WIDTH - 6 || result !== 24'h00008E || wa_out !== 4'd4) begin
            n_fail++;
            $display("FAIL ignore_start: got cyc=%0d result=%h wa=%0d want %0d/00008e/4",
                     cyc, result, wa_out, WIDTH - 6);
        end
        idle_cycles(1);
        n_tests++;
        if (busy !== 1'b0 || result_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL ignore_queued: got busy=%0b valid=%0b want 0/0", busy, result_valid);
        end
    endtask

    task automatic test_flush;
        int seen;
        issue(2'b01, 24'h000064, 24'h000003, 4'd6);
        idle_cycles(9);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        n_tests++;
        if (busy !== 1'b0 || result_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_busy: got busy=%0b valid=%0b want 0/0", busy, result_valid);
        end
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (result_valid) seen++;
        end
        n_tests++;
        if (seen != 0 || result !== 24'h00008E || wa_out !== 4'd4) begin
            n_fail++;
            $display("FAIL flush_suppress: got valids=%0d result=%h wa=%0d want 0/00008e/4",
                     seen, result, wa_out);
        end
        flush = 1'b1;
        issue(2'b00, 24'h000002, 24'h000003, 4'd8);
        flush = 1'b0;
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_start: got busy=%0b want 0", busy);
        end
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (result_valid || busy) seen++;
        end
        n_tests++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL flush_start_quiet: got %0d active cycles want 0", seen);
        end
    endtask

    task automatic test_async_reset;
        int cyc;
        int seen;
        issue(2'b00, 24'h000123, 24'h000456, 4'd5);
        idle_cycles(11);
        #2 reset_n = 1'b0;
        #1;
        n_tests++;
        if ({busy, result_valid, result, wa_out} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got busy=%0b valid=%0b result=%h wa=%0d want all zero",
                     busy, result_valid, result, wa_out);
        end
        @(negedge clk);
        reset_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (result_valid || busy) seen++;
        end
        n_tests++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL reset_discard: got %0d active cycles want 0", seen);
        end
        issue(2'b00, 24'h000123, 24'h000456, 4'd3);
        run_to_valid(cyc);
        n_tests++;
        if (cyc != WIDTH || result !== 24'h04EDC2 || wa_out !== 4'd3) begin
            n_fail++;
            $display("FAIL post_reset: got cyc=%0d result=%h wa=%0d want %0d/04edc2/3",
                     cyc, result, wa_out, WIDTH);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        flush   = 1'b0;
        op      = 2'b00;
        a       = '0;
        b       = '0;
        wa_in   = '0;
        idle_cycles(3);
        test_reset();
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        test_mul();
        test_arith();
        test_div_zero();
        test_back_to_back();
        test_ignored_start();
        test_flush();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
